// File: rtl/mem_stage.sv
// mem_stage: LoongArch memory-access stage.
// Holds the EX payload, waits for data_ok, aligns loads, discards stale responses.
module mem_stage #(
  parameter int PASS_W = 128
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush,
  input  logic              ex_valid,
  input  logic              ex_ready_go,
  output logic              mem_allow_in,
  input  logic              ex_req_hs,
  input  logic [31:0]       ex_pc,
  input  logic [31:0]       ex_result,
  input  logic              ex_mul,
  input  logic [31:0]       ex_mul_result,
  input  logic              ex_res_from_mem,
  input  logic [4:0]        ex_ld_ctrl,
  input  logic              ex_rf_we,
  input  logic [4:0]        ex_rf_waddr,
  input  logic [15:0]       ex_ebus,
  input  logic              ex_ertn,
  input  logic [PASS_W-1:0] ex_pass,
  input  logic              data_sram_data_ok,
  input  logic [31:0]       data_sram_rdata,
  input  logic              wb_allow_in,
  output logic              mem_to_wb_valid,
  output logic [31:0]       mem_pc,
  output logic [31:0]       mem_final_result,
  output logic              mem_rf_we,
  output logic [4:0]        mem_rf_waddr,
  output logic [15:0]       mem_ebus,
  output logic [PASS_W-1:0] mem_pass,
  output logic              mem_byp_we,
  output logic [4:0]        mem_byp_waddr,
  output logic [31:0]       mem_byp_data,
  output logic              mem_byp_stall,
  output logic              st_disable
);

  logic              valid_q, valid_d;
  logic              wait_q, wait_d;
  logic              bufv_q, bufv_d;
  logic [31:0]       buf_q, buf_d;
  logic [1:0]        drop_q, drop_d;

  logic [31:0]       pc_q;
  logic [31:0]       res_q;
  logic              mul_q;
  logic [31:0]       mulr_q;
  logic              rfm_q;
  logic [4:0]        ld_q;
  logic              rfwe_q;
  logic [4:0]        wa_q;
  logic [15:0]       ebus_q;
  logic              ertn_q;
  logic [PASS_W-1:0] pass_q;

  logic        drop_zero;
  logic        ok_live;
  logic        ready_go;
  logic        capture;
  logic        leave;
  logic        accept;
  logic [1:0]  inc;
  logic [1:0]  dec;
  logic        no_exc;
  logic [31:0] raw;
  logic [31:0] sh_b;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] ld_val;
  logic [31:0] final_res;

  assign drop_zero = (drop_q == 2'd0);
  assign ok_live   = data_sram_data_ok & drop_zero;
  assign ready_go  = ~wait_q | ok_live;
  assign mem_allow_in = ~valid_q | (ready_go & wb_allow_in);
  assign capture   = ex_valid & ex_ready_go & mem_allow_in & ~flush;
  assign leave     = valid_q & ready_go & wb_allow_in;
  assign accept    = ok_live & valid_q & wait_q;
  assign inc = {1'b0, flush & ex_req_hs}
             + {1'b0, flush & valid_q & wait_q};
  assign dec = {1'b0, data_sram_data_ok & ~drop_zero};

  // Next-state for occupancy, response tracking and stale-drop count
  always_comb begin
    valid_d = valid_q;
    wait_d  = wait_q;
    bufv_d  = bufv_q;
    buf_d   = buf_q;
    drop_d  = drop_q + inc - dec;
    if (capture) begin
      valid_d = 1'b1;
      wait_d  = ex_req_hs;
      bufv_d  = 1'b0;
    end else begin
      if (accept) begin
        wait_d = 1'b0;
        if (!wb_allow_in) begin
          bufv_d = 1'b1;
          buf_d  = data_sram_rdata;
        end
      end
      if (leave) valid_d = 1'b0;
    end
    if (flush) valid_d = 1'b0;
  end

  // Control state registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      valid_q <= 1'b0;
      wait_q  <= 1'b0;
      bufv_q  <= 1'b0;
      buf_q   <= '0;
      drop_q  <= 2'd0;
    end else begin
      valid_q <= valid_d;
      wait_q  <= wait_d;
      bufv_q  <= bufv_d;
      buf_q   <= buf_d;
      drop_q  <= drop_d;
    end
  end

  // Payload registers, loaded only when an instruction enters
  always_ff @(posedge clk) begin
    if (!resetn) begin
      pc_q   <= '0;
      res_q  <= '0;
      mul_q  <= 1'b0;
      mulr_q <= '0;
      rfm_q  <= 1'b0;
      ld_q   <= '0;
      rfwe_q <= 1'b0;
      wa_q   <= '0;
      ebus_q <= '0;
      ertn_q <= 1'b0;
      pass_q <= '0;
    end else if (capture) begin
      pc_q   <= ex_pc;
      res_q  <= ex_result;
      mul_q  <= ex_mul;
      mulr_q <= ex_mul_result;
      rfm_q  <= ex_res_from_mem;
      ld_q   <= ex_ld_ctrl;
      rfwe_q <= ex_rf_we;
      wa_q   <= ex_rf_waddr;
      ebus_q <= ex_ebus;
      ertn_q <= ex_ertn;
      pass_q <= ex_pass;
    end
  end

  assign raw    = bufv_q ? buf_q : data_sram_rdata;
  assign sh_b   = raw >> {res_q[1:0], 3'b000};
  assign byte_v = sh_b[7:0];
  assign half_v = res_q[1] ? raw[31:16] : raw[15:0];

  // Load alignment and extension
  always_comb begin
    ld_val = '0;
    unique case (1'b1)
      ld_q[4]: ld_val = raw;
      ld_q[3]: ld_val = {24'b0, byte_v};
      ld_q[2]: ld_val = {{24{byte_v[7]}}, byte_v};
      ld_q[1]: ld_val = {16'b0, half_v};
      ld_q[0]: ld_val = {{16{half_v[15]}}, half_v};
      default: ld_val = '0;
    endcase
  end

  assign no_exc    = (ebus_q == 16'd0);
  assign final_res = (rfm_q & no_exc) ? ld_val
                   : mul_q ? mulr_q : res_q;

  assign mem_to_wb_valid  = valid_q & ready_go & ~flush;
  assign mem_pc           = pc_q;
  assign mem_final_result = final_res;
  assign mem_rf_we        = rfwe_q & valid_q & no_exc;
  assign mem_rf_waddr     = wa_q;
  assign mem_ebus         = ebus_q;
  assign mem_pass         = pass_q;
  assign mem_byp_we       = valid_q & rfwe_q;
  assign mem_byp_waddr    = wa_q;
  assign mem_byp_data     = final_res;
  assign mem_byp_stall    = valid_q & rfm_q & ~ready_go;
  assign st_disable       = valid_q & (~no_exc | ertn_q);

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed, table and random checks of mem_stage
// against an instruction-level reference model.
module tb_mem_stage;
  localparam int PW = 128;

  logic clk = 1'b0;
  logic resetn, flush, ex_valid, ex_ready_go, ex_req_hs;
  logic ex_mul, ex_res_from_mem, ex_rf_we, ex_ertn;
  logic dok, wba;
  logic [31:0] ex_pc, ex_result, ex_mul_result, rdata;
  logic [4:0] ex_ld_ctrl, ex_rf_waddr;
  logic [15:0] ex_ebus;
  logic [PW-1:0] ex_pass;

  logic mem_allow_in, mem_to_wb_valid, mem_rf_we;
  logic mem_byp_we, mem_byp_stall, st_disable;
  logic [31:0] mem_pc, mem_final_result, mem_byp_data;
  logic [4:0] mem_rf_waddr, mem_byp_waddr;
  logic [15:0] mem_ebus;
  logic [PW-1:0] mem_pass;

  mem_stage #(.PASS_W(PW)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .ex_valid(ex_valid), .ex_ready_go(ex_ready_go),
    .mem_allow_in(mem_allow_in), .ex_req_hs(ex_req_hs),
    .ex_pc(ex_pc), .ex_result(ex_result), .ex_mul(ex_mul),
    .ex_mul_result(ex_mul_result),
    .ex_res_from_mem(ex_res_from_mem), .ex_ld_ctrl(ex_ld_ctrl),
    .ex_rf_we(ex_rf_we), .ex_rf_waddr(ex_rf_waddr),
    .ex_ebus(ex_ebus), .ex_ertn(ex_ertn), .ex_pass(ex_pass),
    .data_sram_data_ok(dok), .data_sram_rdata(rdata),
    .wb_allow_in(wba), .mem_to_wb_valid(mem_to_wb_valid),
    .mem_pc(mem_pc), .mem_final_result(mem_final_result),
    .mem_rf_we(mem_rf_we), .mem_rf_waddr(mem_rf_waddr),
    .mem_ebus(mem_ebus), .mem_pass(mem_pass),
    .mem_byp_we(mem_byp_we), .mem_byp_waddr(mem_byp_waddr),
    .mem_byp_data(mem_byp_data), .mem_byp_stall(mem_byp_stall),
    .st_disable(st_disable)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model: one in-flight MEM instruction plus stale count
  typedef struct {
    logic [31:0] pc, res, mulr;
    logic mul, rfm, rfwe, ertn;
    logic [4:0] ld, wa;
    logic [15:0] eb;
    logic [PW-1:0] pass;
  } ins_t;

  ins_t cur;
  bit m_valid, m_wait, m_have;
  logic [31:0] m_buf;
  int m_drop;

  typedef struct {
    logic [4:0] ld;
    logic [1:0] a;
    logic [31:0] rd;
    logic [31:0] exp;
  } vec_t;

  task automatic chk(input string nm, input logic [PW-1:0] act,
                     input logic [PW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ext(input logic [4:0] ld,
      input logic [1:0] a, input logic [31:0] raw);
    int unsigned b, h;
    b = (raw >> (8 * a)) & 32'hff;
    h = (raw >> (16 * a[1])) & 32'hffff;
    if (ld[4]) return raw;
    if (ld[3]) return b;
    if (ld[2]) return (b >= 128) ? b - 256 : b;
    if (ld[1]) return h;
    if (ld[0]) return (h >= 32768) ? h - 65536 : h;
    return 32'd0;
  endfunction

  function automatic bit m_rdy();
    return !m_wait || (dok && m_drop == 0);
  endfunction

  function automatic bit m_allow();
    return !m_valid || (m_rdy() && wba);
  endfunction

  task automatic check_outputs();
    logic [31:0] raw, fin;
    bit rdy;
    rdy = m_rdy();
    raw = m_have ? m_buf : rdata;
    if (cur.rfm && cur.eb == 0) fin = ext(cur.ld, cur.res[1:0], raw);
    else if (cur.mul) fin = cur.mulr;
    else fin = cur.res;
    chk("allow_in", mem_allow_in, m_allow());
    chk("to_wb_valid", mem_to_wb_valid, m_valid && rdy && !flush);
    chk("final_result", mem_final_result, fin);
    chk("rf_we", mem_rf_we, cur.rfwe && m_valid && cur.eb == 0);
    chk("rf_waddr", mem_rf_waddr, cur.wa);
    chk("byp_we", mem_byp_we, m_valid && cur.rfwe);
    chk("byp_waddr", mem_byp_waddr, cur.wa);
    chk("byp_data", mem_byp_data, fin);
    chk("byp_stall", mem_byp_stall, m_valid && cur.rfm && !rdy);
    chk("st_disable", st_disable,
        m_valid && (cur.eb != 0 || cur.ertn));
    chk("ebus", mem_ebus, cur.eb);
    chk("pc", mem_pc, cur.pc);
    chk("pass", mem_pass, cur.pass);
  endtask

  task automatic model_edge();
    bit live, rdy, cap;
    int nd;
    if (!resetn) begin
      m_valid = 0; m_wait = 0; m_have = 0; m_buf = '0; m_drop = 0;
      cur = '{default: '0};
      return;
    end
    live = dok && m_drop == 0;
    rdy = m_rdy();
    cap = ex_valid && ex_ready_go && m_allow() && !flush;
    nd = m_drop;
    if (dok && m_drop > 0) nd--;
    if (flush && ex_req_hs) nd++;
    if (flush && m_valid && m_wait) nd++;
    if (flush) m_valid = 0;
    else if (cap) begin
      cur.pc = ex_pc; cur.res = ex_result; cur.mulr = ex_mul_result;
      cur.mul = ex_mul; cur.rfm = ex_res_from_mem;
      cur.rfwe = ex_rf_we; cur.ertn = ex_ertn; cur.ld = ex_ld_ctrl;
      cur.wa = ex_rf_waddr; cur.eb = ex_ebus; cur.pass = ex_pass;
      m_valid = 1; m_wait = ex_req_hs; m_have = 0;
    end else if (m_valid && rdy && wba) begin
      m_valid = 0;
      m_wait = 0;
    end else if (m_valid && m_wait && live) begin
      m_wait = 0; m_have = 1; m_buf = rdata;
    end
    m_drop = nd;
    if (m_drop > 3) begin
      errors++;
      $display("FAIL drop_overflow: got %0d want <=3", m_drop);
    end
  endtask

  // inputs are driven at negedge; outputs checked 1 time unit later
  task automatic step(input bit do_chk = 1'b1);
    #1;
    if (do_chk) check_outputs();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    flush = 0; ex_valid = 0; ex_ready_go = 0; ex_req_hs = 0;
    ex_mul = 0; ex_res_from_mem = 0; ex_rf_we = 0; ex_ertn = 0;
    ex_pc = '0; ex_result = '0; ex_mul_result = '0;
    ex_ld_ctrl = '0; ex_rf_waddr = '0; ex_ebus = '0; ex_pass = '0;
    dok = 0; rdata = '0; wba = 1;
  endtask

  task automatic issue_load(input logic [4:0] ld, input logic [31:0] a,
                            input logic [4:0] wa);
    idle();
    ex_valid = 1; ex_ready_go = 1; ex_req_hs = 1;
    ex_res_from_mem = 1; ex_ld_ctrl = ld; ex_result = a;
    ex_rf_we = 1; ex_rf_waddr = wa; ex_pc = 32'h1c00_0000 + a;
  endtask

  vec_t tbl[8];

  initial begin
    tbl[0] = '{5'b00100, 2'd0, 32'h1234_56F0, 32'hFFFF_FFF0};
    tbl[1] = '{5'b00100, 2'd1, 32'h1234_5670, 32'h0000_0056};
    tbl[2] = '{5'b01000, 2'd2, 32'h12AB_5670, 32'h0000_00AB};
    tbl[3] = '{5'b01000, 2'd3, 32'hFE00_0000, 32'h0000_00FE};
    tbl[4] = '{5'b00001, 2'd0, 32'h0000_8001, 32'hFFFF_8001};
    tbl[5] = '{5'b00001, 2'd2, 32'h7FFF_0000, 32'h0000_7FFF};
    tbl[6] = '{5'b00010, 2'd0, 32'h1234_F00D, 32'h0000_F00D};
    tbl[7] = '{5'b10000, 2'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF};

    // reset
    idle();
    resetn = 0;
    step(0);
    step(0);
    resetn = 1;
    #1;
    chk("rst_allow_in", mem_allow_in, 1'b1);
    chk("rst_to_wb", mem_to_wb_valid, 1'b0);
    chk("rst_result", mem_final_result, 32'd0);
    chk("rst_stall", mem_byp_stall, 1'b0);
    chk("rst_st_dis", st_disable, 1'b0);
    step();

    // ld.b @..3, data_ok two cycles after capture
    issue_load(5'b00100, 32'h0000_1003, 5'd7);
    step();
    idle();
    #1 chk("ldb_stall", mem_byp_stall, 1'b1);
    step();
    dok = 1; rdata = 32'h80FF_1234;
    #1;
    chk("ldb_result", mem_final_result, 32'hFFFF_FF80);
    chk("ldb_rf_we", mem_rf_we, 1'b1);
    chk("ldb_nostall", mem_byp_stall, 1'b0);
    step();
    idle();
    step();

    // ld.hu @..2 with WB stalled after data_ok
    issue_load(5'b00010, 32'h0000_2002, 5'd3);
    step();
    idle();
    dok = 1; rdata = 32'hBEEF_0000; wba = 0;
    #1 chk("ldhu_result", mem_final_result, 32'h0000_BEEF);
    step();
    for (int i = 0; i < 3; i++) begin
      dok = 0; rdata = $urandom; wba = 0;
      #1;
      chk("ldhu_hold", mem_final_result, 32'h0000_BEEF);
      chk("ldhu_hold_v", mem_to_wb_valid, 1'b1);
      step();
    end
    wba = 1;
    #1 chk("ldhu_release", mem_allow_in, 1'b1);
    step();
    #1 chk("ldhu_gone", mem_to_wb_valid, 1'b0);
    step();

    // flush kills a transferring request: its response is dropped
    idle();
    ex_valid = 1; ex_ready_go = 1; ex_req_hs = 1; flush = 1;
    ex_res_from_mem = 1; ex_ld_ctrl = 5'b10000; ex_rf_we = 1;
    step();
    issue_load(5'b10000, 32'h0000_3000, 5'd9);
    step();
    idle();
    dok = 1; rdata = 32'hDEAD_BEEF;
    #1;
    chk("drop_stale_v", mem_to_wb_valid, 1'b0);
    chk("drop_stall", mem_byp_stall, 1'b1);
    step();
    dok = 1; rdata = 32'hCAFE_F00D;
    #1;
    chk("drop_new_v", mem_to_wb_valid, 1'b1);
    chk("drop_new_res", mem_final_result, 32'hCAFE_F00D);
    step();
    idle();
    step();

    // exception held in MEM
    idle();
    ex_valid = 1; ex_ready_go = 1; ex_ebus = 16'h0040;
    ex_rf_we = 1; ex_rf_waddr = 5'd4; ex_res_from_mem = 1;
    ex_ld_ctrl = 5'b10000; ex_result = 32'h0000_55AA;
    step();
    idle();
    wba = 0;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("exc_st_dis", st_disable, 1'b1);
      chk("exc_rf_we", mem_rf_we, 1'b0);
      chk("exc_ebus", mem_ebus, 16'h0040);
      chk("exc_result", mem_final_result, 32'h0000_55AA);
      step();
    end
    wba = 1;
    step();
    #1 chk("exc_clear", st_disable, 1'b0);
    step();

    // mul
    idle();
    ex_valid = 1; ex_ready_go = 1; ex_mul = 1; ex_rf_we = 1;
    ex_mul_result = 32'h1234_5678; ex_rf_waddr = 5'd9;
    step();
    idle();
    #1;
    chk("mul_result", mem_final_result, 32'h1234_5678);
    chk("mul_byp", mem_byp_data, 32'h1234_5678);
    chk("mul_valid", mem_to_wb_valid, 1'b1);
    chk("mul_waddr", mem_byp_waddr, 5'd9);
    step();

    // table of load alignments
    foreach (tbl[i]) begin
      issue_load(tbl[i].ld, 32'h0000_4000 | 32'(tbl[i].a), 5'd5);
      step();
      idle();
      dok = 1; rdata = tbl[i].rd;
      #1 chk("tbl_result", mem_final_result, tbl[i].exp);
      step();
    end
    idle();
    step();

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      int outst;
      idle();
      outst = m_drop + ((m_valid && m_wait) ? 1 : 0);
      flush = ($urandom_range(0, 15) == 0);
      wba = ($urandom_range(0, 3) != 0);
      dok = !flush && outst > 0 && ($urandom_range(0, 2) == 0);
      rdata = $urandom;
      ex_valid = ($urandom_range(0, 3) != 0);
      ex_ready_go = ($urandom_range(0, 4) != 0);
      ex_pc = $urandom; ex_result = $urandom;
      ex_mul_result = $urandom;
      ex_rf_we = $urandom_range(0, 1);
      ex_rf_waddr = 5'($urandom);
      ex_ertn = ($urandom_range(0, 15) == 0);
      ex_ebus = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'd0;
      ex_pass = {$urandom, $urandom, $urandom, $urandom};
      case ($urandom_range(0, 2))
        0: ex_mul = 1;
        1: begin
          ex_res_from_mem = 1;
          ex_ld_ctrl = 5'(1 << $urandom_range(0, 4));
        end
        default: ;
      endcase
      if (ex_valid && ex_ready_go && m_allow()
          && (outst - (dok ? 1 : 0)) <= 2)
        ex_req_hs = ex_res_from_mem || ($urandom_range(0, 5) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
